// File: rtl/fazyrv_rf_pkg.sv
// Shared types and elaboration helpers for the chunk-serial register file.
package fazyrv_rf_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Width of an architectural register address field in the instruction.
    localparam int REG_FIELD_W = 5;

    function automatic int nchunk(input int chunksize);
        return 32 / chunksize;
    endfunction

    function automatic int addr_width(input int nregs);
        return $clog2(nregs);
    endfunction

    function automatic int count_width(input int chunksize);
        return (nchunk(chunksize) > 1) ? $clog2(nchunk(chunksize)) : 1;
    endfunction

    function automatic bit legal_chunksize(input int chunksize);
        return (chunksize == 1) || (chunksize == 2) || (chunksize == 4) || (chunksize == 8);
    endfunction

endpackage

// File: rtl/fazyrv_rf_rotreg.sv
// One 32-bit architectural register that rotates right by CHUNKSIZE when enabled,
// optionally replacing the incoming MSB chunk with write data.
module fazyrv_rf_rotreg #(
    parameter int CHUNKSIZE = 2
) (
    input  logic                 clk_i,
    input  logic                 en_i,
    input  logic                 wr_i,
    input  logic [CHUNKSIZE-1:0] din_i,
    output logic [CHUNKSIZE-1:0] dat_o
);

    logic [31:0] q;

    // NOTE: no reset here -- register contents must survive rst_i, and leaving
    // them unreset lets the bank map onto plain enable flops.
    // NOTE: non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            q <= {(wr_i ? din_i : q[CHUNKSIZE-1:0]), q[31:CHUNKSIZE]};
        end
    end

    assign dat_o = q[CHUNKSIZE-1:0];

endmodule

// File: rtl/fazyrv_rf_seq.sv
// Chunk-serial register file with built-in sequencer; streams rs1/rs2 out and rd in.
// Optional debug port enabled by defining FAZYRV_RF_DBG_EN.
module fazyrv_rf_seq #(
    parameter int CHUNKSIZE = 2,
    parameter int NREGS     = 32
) (
    input  logic                                                clk_i,
    input  logic                                                rst_i,
    input  logic                                                start_i,
    input  logic                                                stall_i,
    input  logic [fazyrv_rf_pkg::REG_FIELD_W-1:0]               rs1_i,
    input  logic [fazyrv_rf_pkg::REG_FIELD_W-1:0]               rs2_i,
    input  logic [fazyrv_rf_pkg::REG_FIELD_W-1:0]               rd_i,
    input  logic                                                we_i,
    input  logic [CHUNKSIZE-1:0]                                res_i,
    output logic [CHUNKSIZE-1:0]                                ra_o,
    output logic [CHUNKSIZE-1:0]                                rb_o,
    output logic [fazyrv_rf_pkg::count_width(CHUNKSIZE)-1:0]    chunk_o,
    output logic                                                busy_o,
    output logic                                                done_o
`ifdef FAZYRV_RF_DBG_EN
    ,
    output logic [31:0]                                         dbg_res_o
`endif
);

    import fazyrv_rf_pkg::*;

    localparam int NCHUNK = nchunk(CHUNKSIZE);
    localparam int AW     = addr_width(NREGS);
    localparam int CW     = count_width(CHUNKSIZE);

    if (!legal_chunksize(CHUNKSIZE) || !((NREGS == 16) || (NREGS == 32))) begin : g_bad_param
        $error("fazyrv_rf_seq: illegal CHUNKSIZE or NREGS");
    end

    state_t         state, state_nxt;
    logic [CW-1:0]  count, count_nxt;
    logic [AW-1:0]  rs1_q, rs2_q, rd_q;
    logic           we_q;
    logic           advance;
    logic           accept;

    logic [CHUNKSIZE-1:0] dat [NREGS];

    // Upper address bits are intentionally ignored when NREGS=16 (aliasing).
    logic unused_addr;
    assign unused_addr = ^{rs1_i, rs2_i, rd_i};

    assign advance = (state == RUN) && !stall_i;
    assign accept  = (state == IDLE) && start_i;

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        done_o    = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_nxt = RUN;
                    count_nxt = '0;
                end
            end
            RUN: begin
                if (advance) begin
                    if (count == CW'(NCHUNK - 1)) begin
                        state_nxt = IDLE;
                        count_nxt = '0;
                        done_o    = 1'b1;
                    end else begin
                        count_nxt = count + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                count_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            count <= '0;
            rs1_q <= '0;
            rs2_q <= '0;
            rd_q  <= '0;
            we_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            if (accept) begin
                rs1_q <= rs1_i[AW-1:0];
                rs2_q <= rs2_i[AW-1:0];
                rd_q  <= rd_i[AW-1:0];
                we_q  <= we_i;
            end
        end
    end

    // x0 is not stored: it reads constant zero and silently drops writes.
    assign dat[0] = '0;

    for (genvar i = 1; i < NREGS; i++) begin : g_reg
        logic wr;
        logic sel;
        assign wr  = we_q && (rd_q == AW'(i));
        assign sel = (rs1_q == AW'(i)) || (rs2_q == AW'(i)) || wr;

        fazyrv_rf_rotreg #(
            .CHUNKSIZE(CHUNKSIZE)
        ) u_reg (
            .clk_i (clk_i),
            .en_i  (advance && sel),
            .wr_i  (wr),
            .din_i (res_i),
            .dat_o (dat[i])
        );
    end

    assign ra_o    = (state == RUN) ? dat[rs1_q] : '0;
    assign rb_o    = (state == RUN) ? dat[rs2_q] : '0;
    assign chunk_o = count;
    assign busy_o  = (state == RUN);

`ifdef FAZYRV_RF_DBG_EN
    // Shadow of the write stream; the final chunk is merged in at the done edge.
    logic [31-CHUNKSIZE:0] wbuf;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wbuf      <= '0;
            dbg_res_o <= '0;
        end else begin
            if (advance) begin
                wbuf <= {res_i, wbuf[31-CHUNKSIZE:CHUNKSIZE]};
            end
            if (done_o) begin
                dbg_res_o <= (we_q && (rd_q != '0)) ? {res_i, wbuf} : 32'h0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fazyrv_rf_seq.sv
// Directed self-checking bench for fazyrv_rf_seq (RV32I/CHUNKSIZE=2 and RV32E/CHUNKSIZE=8 instances).
module tb_fazyrv_rf_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // RV32I, CHUNKSIZE=2 instance
    logic       start = 0, stall = 0, we = 0;
    logic [4:0] rs1 = 0, rs2 = 0, rd = 0;
    logic [1:0] res = 0, ra, rb;
    logic [3:0] chunk;
    logic       busy, done;
`ifdef FAZYRV_RF_DBG_EN
    logic [31:0] dbg, dbg_e;
`endif

    // RV32E, CHUNKSIZE=8 instance
    logic       start_e = 0, stall_e = 0, we_e = 0;
    logic [4:0] rs1_e = 0, rs2_e = 0, rd_e = 0;
    logic [7:0] res_e = 0, ra_e, rb_e;
    logic [1:0] chunk_e;
    logic       busy_e, done_e;

    fazyrv_rf_seq #(.CHUNKSIZE(2), .NREGS(32)) u_dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall),
        .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd), .we_i(we), .res_i(res),
        .ra_o(ra), .rb_o(rb), .chunk_o(chunk), .busy_o(busy), .done_o(done)
`ifdef FAZYRV_RF_DBG_EN
        , .dbg_res_o(dbg)
`endif
    );

    fazyrv_rf_seq #(.CHUNKSIZE(8), .NREGS(16)) u_dut_e (
        .clk_i(clk), .rst_i(rst), .start_i(start_e), .stall_i(stall_e),
        .rs1_i(rs1_e), .rs2_i(rs2_e), .rd_i(rd_e), .we_i(we_e), .res_i(res_e),
        .ra_o(ra_e), .rb_o(rb_e), .chunk_o(chunk_e), .busy_o(busy_e), .done_o(done_e)
`ifdef FAZYRV_RF_DBG_EN
        , .dbg_res_o(dbg_e)
`endif
    );

    // One transaction on the CHUNKSIZE=2 instance; collects streamed words and
    // counts busy cycles, done pulses and chunk/stability anomalies (bounded).
    task automatic txn(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] d,
                       input logic w, input logic [31:0] wdata,
                       input int stall_at, input int stall_len, input logic hold_start,
                       output logic [31:0] ra_w, output logic [31:0] rb_w,
                       output int busy_n, output int done_n, output int bad_n);
        int k, st;
        logic [1:0] ra_hold;
        @(negedge clk);
        start = 1'b1; rs1 = a1; rs2 = a2; rd = d; we = w;
        @(negedge clk);
        start = hold_start;
        k = 0; st = 0; busy_n = 0; done_n = 0; bad_n = 0;
        ra_w = '0; rb_w = '0; ra_hold = '0;
        for (int cyc = 0; cyc < 64 && busy === 1'b1; cyc++) begin
            stall = (k == stall_at) && (st < stall_len);
            res = wdata[2*k +: 2];
            #1;
            busy_n++;
            if (done === 1'b1) done_n++;
            if (chunk !== 4'(k)) bad_n++;
            if (stall) begin
                if (st > 0 && ra !== ra_hold) bad_n++;
                ra_hold = ra;
                st++;
            end else begin
                if (st > 0 && k == stall_at && ra !== ra_hold) bad_n++;
                ra_w[2*k +: 2] = ra;
                rb_w[2*k +: 2] = rb;
                k++;
            end
            @(negedge clk);
        end
        start = 1'b0; stall = 1'b0; we = 1'b0;
    endtask

    task automatic txn_e(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] d,
                         input logic w, input logic [31:0] wdata,
                         output logic [31:0] ra_w, output logic [31:0] rb_w,
                         output int busy_n, output int done_n, output int bad_n);
        int k;
        @(negedge clk);
        start_e = 1'b1; rs1_e = a1; rs2_e = a2; rd_e = d; we_e = w;
        @(negedge clk);
        start_e = 1'b0;
        k = 0; busy_n = 0; done_n = 0; bad_n = 0; ra_w = '0; rb_w = '0;
        for (int cyc = 0; cyc < 32 && busy_e === 1'b1; cyc++) begin
            res_e = wdata[8*k +: 8];
            #1;
            busy_n++;
            if (done_e === 1'b1) done_n++;
            if (chunk_e !== 2'(k)) bad_n++;
            ra_w[8*k +: 8] = ra_e;
            rb_w[8*k +: 8] = rb_e;
            k++;
            @(negedge clk);
        end
        we_e = 1'b0;
    endtask

    logic [31:0] ra_w, rb_w;
    int busy_n, done_n, bad_n;

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if (chunk !== 4'd0) begin errors++; $display("FAIL reset_chunk got %0d exp 0", chunk); end
        checks++; if ({ra, rb} !== 4'h0) begin errors++; $display("FAIL reset_ra_rb got %h exp 0", {ra, rb}); end
        checks++; if ({busy_e, ra_e} !== 9'h0) begin errors++; $display("FAIL reset_e got %h exp 0", {busy_e, ra_e}); end
`ifdef FAZYRV_RF_DBG_EN
        checks++; if (dbg !== 32'h0) begin errors++; $display("FAIL reset_dbg got %h exp 0", dbg); end
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_write_x5();
        txn(5'd0, 5'd0, 5'd5, 1'b1, 32'hDEADBEEF, -1, 0, 1'b0, ra_w, rb_w, busy_n, done_n, bad_n);
        checks++; if (busy_n !== 16) begin errors++; $display("FAIL x5_wr_busy got %0d exp 16", busy_n); end
        checks++; if (done_n !== 1) begin errors++; $display("FAIL x5_wr_done got %0d exp 1", done_n); end
        checks++; if (bad_n !== 0) begin errors++; $display("FAIL x5_wr_chunk got %0d exp 0", bad_n); end
        checks++; if (ra_w !== 32'h0) begin errors++; $display("FAIL x5_wr_ra_x0 got %h exp 0", ra_w); end
`ifdef FAZYRV_RF_DBG_EN
        checks++; if (dbg !== 32'hDEADBEEF) begin errors++; $display("FAIL x5_dbg got %h exp deadbeef", dbg); end
`endif
        txn(5'd5, 5'd0, 5'd0, 1'b0, 32'h0, -1, 0, 1'b0, ra_w, rb_w, busy_n, done_n, bad_n);
        checks++; if (ra_w !== 32'hDEADBEEF) begin errors++; $display("FAIL x5_rd_ra got %h exp deadbeef", ra_w); end
        checks++; if (rb_w !== 32'h0) begin errors++; $display("FAIL x5_rd_rb got %h exp 0", rb_w); end
        checks++; if (busy_n !== 16) begin errors++; $display("FAIL x5_rd_busy got %0d exp 16", busy_n); end
        checks++; if (done_n !== 1) begin errors++; $display("FAIL x5_rd_done got %0d exp 1", done_n); end
    endtask

    task automatic test_write_x0();
        txn(5'd0, 5'd0, 5'd0, 1'b1, 32'hFFFFFFFF, -1, 0, 1'b0, ra_w, rb_w, busy_n, done_n, bad_n);
`ifdef FAZYRV_RF_DBG_EN
        checks++; if (dbg !== 32'h0) begin errors++; $display("FAIL x0_dbg got %h exp 0", dbg); end
`endif
        txn(5'd0, 5'd0, 5'd0, 1'b0, 32'h0, -1, 0, 1'b0, ra_w, rb_w, busy_n, done_n, bad_n);
        checks++; if ({ra_w, rb_w} !== 64'h0) begin errors++; $display("FAIL x0_read got %h exp 0", {ra_w, rb_w}); end
    endtask

    task automatic test_read_before_write();
        txn(5'd0, 5'd0, 5'd7, 1'b1, 32'h12345678, -1, 0, 1'b0, ra_w, rb_w, busy_n, done_n, bad_n);
        txn(5'd7, 5'd7, 5'd7, 1'b1, 32'hCAFEF00D, -1, 0, 1'b0, ra_w, rb_w, busy_n, done_n, bad_n);
        checks++; if (ra_w !== 32'h12345678) begin errors++; $display("FAIL rbw_ra got %h exp 12345678", ra_w); end
        checks++; if (rb_w !== 32'h12345678) begin errors++; $display("FAIL rbw_rb got %h exp 12345678", rb_w); end
        txn(5'd7, 5'd0, 5'd0, 1'b0, 32'h0, -1, 0, 1'b0, ra_w, rb_w, busy_n, done_n, bad_n);
        checks++; if (ra_w !== 32'hCAFEF00D) begin errors++; $display("FAIL rbw_after got %h exp cafef00d", ra_w); end
    endtask

    task automatic test_stall();
        txn(5'd0, 5'd0, 5'd9, 1'b1, 32'h0BADCAFE, -1, 0, 1'b0, ra_w, rb_w, busy_n, done_n, bad_n);
        txn(5'd5, 5'd5, 5'd10, 1'b1, 32'h55AA33CC, 4, 3, 1'b0, ra_w, rb_w, busy_n, done_n, bad_n);
        checks++; if (busy_n !== 19) begin errors++; $display("FAIL stall_busy got %0d exp 19", busy_n); end
        checks++; if (done_n !== 1) begin errors++; $display("FAIL stall_done got %0d exp 1", done_n); end
        checks++; if (bad_n !== 0) begin errors++; $display("FAIL stall_hold got %0d exp 0", bad_n); end
        checks++; if (ra_w !== 32'hDEADBEEF) begin errors++; $display("FAIL stall_ra got %h exp deadbeef", ra_w); end
        checks++; if (rb_w !== 32'hDEADBEEF) begin errors++; $display("FAIL stall_rb got %h exp deadbeef", rb_w); end
        txn(5'd9, 5'd10, 5'd0, 1'b0, 32'h0, -1, 0, 1'b0, ra_w, rb_w, busy_n, done_n, bad_n);
        checks++; if (ra_w !== 32'h0BADCAFE) begin errors++; $display("FAIL stall_x9 got %h exp 0badcafe", ra_w); end
        checks++; if (rb_w !== 32'h55AA33CC) begin errors++; $display("FAIL stall_x10 got %h exp 55aa33cc", rb_w); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start = 1'b1; rs1 = 5'd5; rs2 = 5'd0; rd = 5'd0; we = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (chunk !== 4'd3) begin errors++; $display("FAIL mid_chunk got %0d exp 3", chunk); end
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b exp 0", busy); end
        checks++; if (chunk !== 4'd0) begin errors++; $display("FAIL mid_rst_chunk got %0d exp 0", chunk); end
        @(negedge clk);
        rst = 1'b0;
        txn(5'd9, 5'd0, 5'd0, 1'b0, 32'h0, -1, 0, 1'b0, ra_w, rb_w, busy_n, done_n, bad_n);
        checks++; if (ra_w !== 32'h0BADCAFE) begin errors++; $display("FAIL mid_x9 got %h exp 0badcafe", ra_w); end
        checks++; if (busy_n !== 16) begin errors++; $display("FAIL mid_busy got %0d exp 16", busy_n); end
    endtask

    task automatic test_back_to_back();
        // start held high through the done cycle must not chain a second transaction
        txn(5'd9, 5'd0, 5'd0, 1'b0, 32'h0, -1, 0, 1'b1, ra_w, rb_w, busy_n, done_n, bad_n);
        checks++; if (busy_n !== 16) begin errors++; $display("FAIL b2b_busy got %0d exp 16", busy_n); end
        checks++; if (done_n !== 1) begin errors++; $display("FAIL b2b_done got %0d exp 1", done_n); end
        checks++; if (ra_w !== 32'h0BADCAFE) begin errors++; $display("FAIL b2b_ra got %h exp 0badcafe", ra_w); end
    endtask

    task automatic test_rv32e();
        txn_e(5'd0, 5'd0, 5'd19, 1'b1, 32'hA5A5A5A5, ra_w, rb_w, busy_n, done_n, bad_n);
        checks++; if (busy_n !== 4) begin errors++; $display("FAIL e_wr_busy got %0d exp 4", busy_n); end
        checks++; if (done_n !== 1) begin errors++; $display("FAIL e_wr_done got %0d exp 1", done_n); end
`ifdef FAZYRV_RF_DBG_EN
        checks++; if (dbg_e !== 32'hA5A5A5A5) begin errors++; $display("FAIL e_dbg got %h exp a5a5a5a5", dbg_e); end
`endif
        txn_e(5'd3, 5'd19, 5'd0, 1'b0, 32'h0, ra_w, rb_w, busy_n, done_n, bad_n);
        checks++; if (ra_w !== 32'hA5A5A5A5) begin errors++; $display("FAIL e_rd_ra got %h exp a5a5a5a5", ra_w); end
        checks++; if (rb_w !== 32'hA5A5A5A5) begin errors++; $display("FAIL e_rd_alias got %h exp a5a5a5a5", rb_w); end
        checks++; if (bad_n !== 0) begin errors++; $display("FAIL e_chunk got %0d exp 0", bad_n); end
    endtask

    initial begin
        test_reset();
        test_write_x5();
        test_write_x0();
        test_read_before_write();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_rv32e();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fazyrv_rf_seq.md
Name: fazyrv_rf_seq

Overview:
Chunk-serial register file with its own sequencer, parametrised in chunk width and register count (RV32I/RV32E). On a start request it streams rs1/rs2 out and rd in, CHUNKSIZE bits per cycle, over NCHUNK = 32/CHUNKSIZE cycles, and signals completion. To save energy, only the addressed registers rotate; all others hold. Sits between decode/control and the chunked ALU of the core.

Parameters:
CHUNKSIZE, 2, data path width per cycle; legal values 1, 2, 4, 8.
NREGS, 32, architectural register count; 32 (RV32I) or 16 (RV32E).

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
start_i  in  1  request transaction; sampled in IDLE only
stall_i  in  1  hold current chunk; no shift, no count
rs1_i  in  5  source address A; latched at accepted start
rs2_i  in  5  source address B; latched at accepted start
rd_i  in  5  destination address; latched at accepted start
we_i  in  1  write enable for the transaction; latched at accepted start
res_i  in  CHUNKSIZE  write data chunk for the current cycle
ra_o  out  CHUNKSIZE  current chunk of rs1
rb_o  out  CHUNKSIZE  current chunk of rs2
chunk_o  out  log2(NCHUNK) (min 1)  current chunk index, LSB chunk first
busy_o  out  1  transaction in progress
done_o  out  1  single-cycle pulse on final advancing cycle

Behaviour:
- Reset: the async assert forces state IDLE, count 0, and latched addresses/we to 0. Outputs busy_o=0, done_o=0, chunk_o=0, ra_o=rb_o=0. Register contents are not reset.
- Address decode: only the low log2(NREGS) bits are used, so NREGS=16 aliases x16..x31 to x0..x15. x0 always reads 0. Writes to x0 are dropped.
- FSM has two states, IDLE and RUN.
  - IDLE: start_i=1 latches rs1/rs2/rd/we and moves to RUN with count=0 on the next edge. ra_o/rb_o are 0 in IDLE.
  - RUN: ra_o/rb_o are combinational from bits [CHUNKSIZE-1:0] of the latched registers.
  - A RUN cycle with stall_i=0 is an advancing cycle: each selected register (rs1, rs2, and rd if we) rotates right by CHUNKSIZE, and count increments.
  - The incoming MSB chunk is res_i for rd when we is set, otherwise the register's own LSB chunk.
  - A register that is selected more than once rotates exactly once per cycle.
  - A RUN cycle with stall_i=1 holds state, count, and register contents; outputs stay stable.
  - On the advancing cycle with count=NCHUNK-1: done_o=1 combinationally, and the next state is IDLE with count=0. start_i in that same cycle is ignored.
- After a transaction, every register is realigned: it has rotated either 32 bits or not at all.
- rs1==rd or rs2==rd: the read returns the old value. The chunk is read at the LSB before the write enters at the MSB.
- start_i while in RUN is ignored; there is no queueing.
- Latency: start edge +1 gives chunk 0 on ra_o. Unstalled throughput is 1 transaction per NCHUNK+1 cycles.
- Reset during RUN: return to IDLE. The contents of the latched rs1/rs2/rd registers are undefined afterwards; all other registers are preserved.

Optional Feature:
FAZYRV_RF_DBG_EN:
- Defined: adds output dbg_res_o [31:0], holding the full value written to rd by the last completed write transaction. It updates at the edge where done_o=1, reads 0 for x0 or we=0, and resets to 0.
- Undefined: the port and its logic are absent.

Decomposition:
- Package fazyrv_rf_pkg holds:
  - the state enum (IDLE, RUN);
  - function nchunk(CHUNKSIZE);
  - the address-width constant derived from NREGS;
  - the legal-CHUNKSIZE check.
- Sub-module fazyrv_rf_rotreg: one 32-bit rotating register with en_i, wr_i, din_i [CHUNKSIZE], dat_o [CHUNKSIZE]. It is instantiated NREGS-1 times.

Test Plan:
- Write x5: CHUNKSIZE=2, we=1, rd=5, res_i streams 0xDEADBEEF LSB-first over 16 cycles. Then read with rs1=5 → ra_o chunks reconstruct 0xDEADBEEF; done_o pulses once per transaction; busy_o high for 16 cycles.
- Write x0: rd=0, we=1, res_i=0xFFFFFFFF; then read rs1=0 → ra_o=0 on every chunk.
- Read-before-write: x7 holds 0x12345678; rs1=rs2=rd=7, res_i=0xCAFEF00D → ra_o/rb_o stream 0x12345678; a subsequent read of x7 returns 0xCAFEF00D.
- Stall and non-selected hold: stall_i=1 for 3 cycles at chunk 4 → chunk_o stays 4, ra_o stable, total busy 19 cycles, result correct. x9, not addressed, is unchanged.
- Reset mid-transaction: assert rst_i at chunk 3 → busy_o=0, chunk_o=0 immediately. x9 is preserved and the next transaction runs normally.
- RV32E aliasing: NREGS=16, CHUNKSIZE=8; write x3=0xA5A5A5A5 with rd=19 → read rs1=3 returns 0xA5A5A5A5 in 4 chunks. With FAZYRV_RF_DBG_EN, dbg_res_o=0xA5A5A5A5.
